// File: rtl/if0_pc_gen.sv
// IF0 fetch-PC generator: builds one aligned fetch group per accepted cycle,
// applying prioritised redirects, same-cycle BTB predictions, IDLE halt and ADEF packets.
module if0_pc_gen #(
  parameter int unsigned FETCH_W  = 2,
  parameter int unsigned NREDIR   = 4,
  parameter logic [31:0] PC_RESET = 32'h1c000000,
  localparam int unsigned SLOT_W  = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREDIR-1:0]      redir_valid,
  input  logic [NREDIR*32-1:0]   redir_pc,
  input  logic                   halt_req,
  output logic [31:0]            fetch_pc,
  input  logic                   pred_taken,
  input  logic [SLOT_W-1:0]      pred_slot,
  input  logic [31:0]            pred_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [FETCH_W-1:0]     out_mask,
  output logic                   out_taken,
  output logic [31:0]            out_next_pc,
  output logic                   out_adef,
  output logic                   halted
);

  localparam logic [31:0] GROUP_BYTES = 32'(4 * FETCH_W);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [FETCH_W-1:0] mask;
    logic               taken;
    logic [31:0]        next_pc;
    logic               adef;
  } pkt_t;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  pkt_t        pkt_q, pkt_d;

  logic [SLOT_W-1:0]  slot;
  logic [31:0]        seq_next;
  logic               adef;
  logic               pred_hit;
  logic [FETCH_W-1:0] grp_mask;
  logic [FETCH_W-1:0] adef_mask;
  logic               redir_any;
  logic [31:0]        redir_tgt;

  if (FETCH_W > 1) begin : g_slot
    assign slot = pc_q[$clog2(FETCH_W)+1:2];
  end else begin : g_slot_single
    assign slot = '0;
  end

  assign seq_next  = (pc_q & ~(GROUP_BYTES - 32'd1)) + GROUP_BYTES;
  assign adef      = (pc_q[1:0] != 2'b00);
  // A prediction for a slot before the entry slot belongs to an earlier pass
  // through this group and must not truncate it.
  assign pred_hit  = pred_taken && (FETCH_W == 1 || pred_slot >= slot);
  assign adef_mask = FETCH_W'(1) << slot;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    grp_mask = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (k >= int'(slot) && (!pred_hit || FETCH_W == 1 || k <= int'(pred_slot))) begin
        grp_mask[k] = 1'b1;
      end
    end
  end

  // Scan from the lowest priority upwards so the lowest index wins.
  always_comb begin
    redir_any = 1'b0;
    redir_tgt = '0;
    for (int i = NREDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        redir_any = 1'b1;
        redir_tgt = redir_pc[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    pkt_d       = pkt_q;
    if (redir_any) begin
      state_d     = S_RUN;
      pc_d        = redir_tgt;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (state_q == S_RUN) begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          pkt_d.pc    = pc_q;
          pkt_d.adef  = adef;
          if (adef) begin
            // Misaligned entry: report it once, then park until a redirect.
            pkt_d.mask    = adef_mask;
            pkt_d.taken   = 1'b0;
            pkt_d.next_pc = pc_q;
            state_d       = S_HALT;
          end else begin
            pkt_d.mask    = grp_mask;
            pkt_d.taken   = pred_hit;
            pkt_d.next_pc = pred_hit ? pred_pc : seq_next;
            pc_d          = pred_hit ? pred_pc : seq_next;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_RUN;
      pc_q        <= PC_RESET;
      out_valid_q <= 1'b0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      pkt_q       <= pkt_d;
    end
  end

  assign fetch_pc    = pc_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = pkt_q.pc;
  assign out_mask    = pkt_q.mask;
  assign out_taken   = pkt_q.taken;
  assign out_next_pc = pkt_q.next_pc;
  assign out_adef    = pkt_q.adef;
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_if0_pc_gen.sv
// Bench for if0_pc_gen: transaction-level reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_if0_pc_gen;

  localparam int unsigned FW     = 2;
  localparam int unsigned NR     = 4;
  localparam logic [31:0] PC_RST = 32'h1c000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [NR-1:0]     redir_valid;
  logic [NR*32-1:0]  redir_pc;
  logic              halt_req;
  logic [31:0]       fetch_pc;
  logic              pred_taken;
  logic [0:0]        pred_slot;
  logic [31:0]       pred_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [FW-1:0]     out_mask;
  logic              out_taken;
  logic [31:0]       out_next_pc;
  logic              out_adef;
  logic              halted;

  // Single-entry BTB stub answering for the current fetch_pc.
  logic        btb_en;
  logic [31:0] btb_pc;
  logic [0:0]  btb_slot;
  logic [31:0] btb_tgt;
  assign pred_taken = btb_en && (fetch_pc == btb_pc);
  assign pred_slot  = btb_slot;
  assign pred_pc    = btb_tgt;

  if0_pc_gen #(.FETCH_W(FW), .NREDIR(NR), .PC_RESET(PC_RST)) u_dut (
    .clk(clk), .rstn(rstn), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .halt_req(halt_req), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .pred_slot(pred_slot), .pred_pc(pred_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_mask(out_mask),
    .out_taken(out_taken), .out_next_pc(out_next_pc), .out_adef(out_adef),
    .halted(halted)
  );

  // Second instance free-running from a reset PC at the top of the address space.
  logic [31:0]   w_fetch_pc, w_out_pc, w_out_next_pc;
  logic          w_out_valid, w_out_taken, w_out_adef, w_halted;
  logic [FW-1:0] w_out_mask;

  if0_pc_gen #(.FETCH_W(FW), .NREDIR(NR), .PC_RESET(32'hFFFFFFF8)) u_wrap (
    .clk(clk), .rstn(rstn), .redir_valid('0), .redir_pc('0),
    .halt_req(1'b0), .fetch_pc(w_fetch_pc), .pred_taken(1'b0),
    .pred_slot(1'b0), .pred_pc(32'h0), .out_valid(w_out_valid),
    .out_ready(1'b1), .out_pc(w_out_pc), .out_mask(w_out_mask),
    .out_taken(w_out_taken), .out_next_pc(w_out_next_pc), .out_adef(w_out_adef),
    .halted(w_halted)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the generator must have produced after each edge.
  logic [31:0]   m_pc, m_opc, m_next;
  logic [FW-1:0] m_mask;
  logic          m_halt, m_ov, m_taken, m_adef;

  always @(posedge clk) begin : model
    int unsigned grp, first, last;
    bit          issue, tk;
    grp = 4 * FW;
    if (!rstn) begin
      m_pc = PC_RST; m_halt = 0; m_ov = 0;
      m_opc = 0; m_mask = 0; m_taken = 0; m_next = 0; m_adef = 0;
    end else if (|redir_valid) begin
      for (int i = NR - 1; i >= 0; i--)
        if (redir_valid[i]) m_pc = redir_pc[32*i +: 32];
      m_ov = 0;
      m_halt = 0;
    end else begin
      issue = !m_halt && !halt_req && (!m_ov || out_ready);
      if (!m_halt && halt_req) m_halt = 1;
      if (m_ov && out_ready) m_ov = 0;
      if (issue) begin
        first = (m_pc % grp) / 4;
        m_opc = m_pc;
        m_ov  = 1;
        if (m_pc % 4 != 0) begin
          m_mask  = 0;
          m_mask[first] = 1'b1;
          m_taken = 0;
          m_adef  = 1;
          m_next  = m_pc;
          m_halt  = 1;
        end else begin
          tk   = btb_en && (btb_pc == m_pc) && (btb_slot >= first);
          last = tk ? btb_slot : FW - 1;
          m_mask = 0;
          for (int k = 0; k < FW; k++)
            if (k >= first && k <= last) m_mask[k] = 1'b1;
          m_taken = tk;
          m_adef  = 0;
          m_next  = tk ? btb_tgt : (m_pc - (m_pc % grp) + grp);
          m_pc    = m_next;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m.fetch_pc",    fetch_pc,    m_pc);
      check("m.out_valid",   out_valid,   m_ov);
      check("m.halted",      halted,      m_halt);
      check("m.out_pc",      out_pc,      m_opc);
      check("m.out_mask",    out_mask,    m_mask);
      check("m.out_taken",   out_taken,   m_taken);
      check("m.out_next_pc", out_next_pc, m_next);
      check("m.out_adef",    out_adef,    m_adef);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pkt(input string name, input logic [31:0] pc, input logic [FW-1:0] mask,
                     input logic taken, input logic [31:0] next);
    check({name, ".valid"}, out_valid, 1'b1);
    check({name, ".pc"},    out_pc,    pc);
    check({name, ".mask"},  out_mask,  mask);
    check({name, ".taken"}, out_taken, taken);
    check({name, ".next"},  out_next_pc, next);
  endtask

  initial begin
    rstn = 0; redir_valid = '0; redir_pc = '0; halt_req = 0; out_ready = 1;
    btb_en = 0; btb_pc = '0; btb_slot = '0; btb_tgt = '0;
    @(negedge clk);
    chk_en = 1'b1;
    tick(2);
    check("rst.valid", out_valid, 1'b0);
    check("rst.fetch", fetch_pc, 32'h1c000000);
    check("rst.pc", out_pc, 32'h0);
    check("rst.mask", out_mask, 2'b00);
    check("rst.next", out_next_pc, 32'h0);
    check("rst.halted", halted, 1'b0);
    check("wrap.rst_fetch", w_fetch_pc, 32'hFFFFFFF8);
    check("wrap.rst_valid", w_out_valid, 1'b0);

    // Sequential fetch from reset.
    rstn = 1;
    tick;
    pkt("seq0", 32'h1c000000, 2'b11, 1'b0, 32'h1c000008);
    check("wrap.pc0", w_out_pc, 32'hFFFFFFF8);
    check("wrap.next0", w_out_next_pc, 32'h00000000);
    tick;
    pkt("seq1", 32'h1c000008, 2'b11, 1'b0, 32'h1c000010);
    check("wrap.pc1", w_out_pc, 32'h00000000);
    check("wrap.next1", w_out_next_pc, 32'h00000008);
    tick;
    pkt("seq2", 32'h1c000010, 2'b11, 1'b0, 32'h1c000018);

    // Redirect into the middle of a group.
    redir_valid = 4'b0010; redir_pc[63:32] = 32'h1c000104;
    tick;
    check("redir.flush", out_valid, 1'b0);
    check("redir.fetch", fetch_pc, 32'h1c000104);
    redir_valid = '0;
    tick;
    pkt("redir.p0", 32'h1c000104, 2'b10, 1'b0, 32'h1c000108);
    tick;
    pkt("redir.p1", 32'h1c000108, 2'b11, 1'b0, 32'h1c000110);

    // Two simultaneous redirects: lower index wins.
    redir_pc[63:32] = 32'h00000100; redir_pc[95:64] = 32'h00000200; redir_valid = 4'b0110;
    tick;
    check("prio.fetch", fetch_pc, 32'h00000100);
    redir_valid = '0;
    tick;
    pkt("prio.p0", 32'h00000100, 2'b11, 1'b0, 32'h00000108);

    // Predicted-taken branch in slot 0.
    btb_en = 1; btb_pc = 32'h1c000020; btb_slot = 1'b0; btb_tgt = 32'h1c000400;
    redir_valid = 4'b0001; redir_pc[31:0] = 32'h1c000020;
    tick;
    redir_valid = '0;
    tick;
    pkt("bp.p0", 32'h1c000020, 2'b01, 1'b1, 32'h1c000400);
    tick;
    pkt("bp.p1", 32'h1c000400, 2'b11, 1'b0, 32'h1c000408);

    // Prediction for a slot before the entry slot is ignored.
    btb_pc = 32'h1c000204; btb_slot = 1'b0; btb_tgt = 32'h1c000800;
    redir_valid = 4'b0001; redir_pc[31:0] = 32'h1c000204;
    tick;
    redir_valid = '0;
    tick;
    pkt("bp.stale", 32'h1c000204, 2'b10, 1'b0, 32'h1c000208);

    // Prediction in the entry slot itself.
    btb_pc = 32'h1c00020c; btb_slot = 1'b1; btb_tgt = 32'h1c000900;
    redir_valid = 4'b0001; redir_pc[31:0] = 32'h1c00020c;
    tick;
    redir_valid = '0;
    tick;
    pkt("bp.slot1", 32'h1c00020c, 2'b10, 1'b1, 32'h1c000900);

    // Downstream stall, then a redirect flushes the held packet.
    btb_en = 0; out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      pkt("stall", 32'h1c00020c, 2'b10, 1'b1, 32'h1c000900);
      check("stall.fetch", fetch_pc, 32'h1c000900);
    end
    redir_valid = 4'b1000; redir_pc[127:96] = 32'h1c001000;
    tick;
    check("stall.flush", out_valid, 1'b0);
    check("stall.fetch2", fetch_pc, 32'h1c001000);
    redir_valid = '0; out_ready = 1;
    tick;
    pkt("stall.resume", 32'h1c001000, 2'b11, 1'b0, 32'h1c001008);

    // IDLE halt, then redirect to a misaligned target.
    halt_req = 1;
    tick;
    check("halt.halted", halted, 1'b1);
    check("halt.valid", out_valid, 1'b0);
    halt_req = 0;
    tick(3);
    check("halt.stay", halted, 1'b1);
    check("halt.novalid", out_valid, 1'b0);
    check("halt.fetch", fetch_pc, 32'h1c001008);
    redir_valid = 4'b0100; redir_pc[95:64] = 32'h1c000102;
    tick;
    check("adef.run", halted, 1'b0);
    redir_valid = '0;
    tick;
    pkt("adef", 32'h1c000102, 2'b01, 1'b0, 32'h1c000102);
    check("adef.flag", out_adef, 1'b1);
    check("adef.halted", halted, 1'b1);
    tick;
    check("adef.drain", out_valid, 1'b0);
    check("adef.fetch", fetch_pc, 32'h1c000102);

    // Halt while a packet is stalled: the packet survives until accepted.
    redir_valid = 4'b0001; redir_pc[31:0] = 32'h1c000000;
    tick;
    redir_valid = '0; out_ready = 0;
    tick;
    pkt("hstall.p", 32'h1c000000, 2'b11, 1'b0, 32'h1c000008);
    halt_req = 1;
    tick;
    check("hstall.halted", halted, 1'b1);
    pkt("hstall.hold", 32'h1c000000, 2'b11, 1'b0, 32'h1c000008);
    halt_req = 0;
    tick;
    check("hstall.hold2", out_valid, 1'b1);
    out_ready = 1;
    tick;
    check("hstall.drain", out_valid, 1'b0);

    // Redirect overrides a simultaneous halt request.
    redir_valid = 4'b0010; redir_pc[63:32] = 32'h1c000040; halt_req = 1;
    tick;
    check("rh.halted", halted, 1'b0);
    redir_valid = '0; halt_req = 0;
    tick;
    pkt("rh.p", 32'h1c000040, 2'b11, 1'b0, 32'h1c000048);

    tick(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if0_pc_gen.md
Name: if0_pc_gen

Overview:
Parametrised fetch-PC generator for the IF0 stage. It produces one aligned fetch group of FETCH_W instructions per accepted cycle, with a per-slot valid mask. Redirect sources are arbitrated by fixed priority, and BTB predictions are applied in the same cycle they are looked up. It also handles IDLE halt and misaligned-target (ADEF) packets. A registered valid/ready output stage feeds IF1/TLB lookup.

Parameters:
FETCH_W, 2, instructions per fetch group; power of 2, range 1..8
NREDIR, 4, number of redirect sources; index 0 has the highest priority (e.g. WB, EX, ID, PRIV)
PC_RESET, 32'h1c000000, PC value loaded on reset

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
redir_valid  in  NREDIR  per-source redirect request
redir_pc  in  NREDIR*32  redirect targets; source i occupies bits [32i+31:32i]
halt_req  in  1  IDLE executed; stop generating packets
fetch_pc  out  32  current PC register, used for the BTB lookup key
pred_taken  in  1  BTB hit/taken for fetch_pc, combinational this cycle
pred_slot  in  max(1,log2 FETCH_W)  slot of the taken branch within the group
pred_pc  in  32  predicted target
out_valid  out  1  packet valid
out_ready  in  1  downstream accepts the packet
out_pc  out  32  packet PC (unaligned entry PC, as fetched)
out_mask  out  FETCH_W  valid instruction slots
out_taken  out  1  packet ends in a predicted-taken branch
out_next_pc  out  32  PC the generator advanced to after this packet
out_adef  out  1  packet PC misaligned (pc[1:0]!=0)
halted  out  1  generator in HALT state

Behaviour:
- Reset (rstn=0 at a clk edge):
  - pc=PC_RESET; state=RUN.
  - out_valid=0, out_mask=0, out_taken=0, out_adef=0, out_pc=0, out_next_pc=0, halted=0.
- Derived values:
  - OFS = log2(FETCH_W)+2.
  - base = {pc[31:OFS], OFS'b0}.
  - slot = pc[OFS-1:2].
  - seq_next = base + 4*FETCH_W, wrapping mod 2^32 (0xFFFFFFF8 + 8 = 0).
- Mask:
  - Bit k is set when k >= slot.
  - If pred_taken, additionally require k <= pred_slot.
  - A pred_slot below slot is treated as not-taken.
- States:
  - RUN: generates packets.
  - HALT: no generation; halted=1.
- fire = (state==RUN) && no redirect && (!out_valid || out_ready).
- On fire:
  - Output registers load {pc, mask, taken, next, adef} and out_valid<=1.
  - pc <= taken ? pred_pc : seq_next.
- When out_valid && out_ready && !fire: out_valid<=0.
- Latency: redirect at edge t sets pc; its packet becomes valid after edge t+1.
- Redirect (any redir_valid):
  - Lowest index wins; pc<=redir_pc[winner]; out_valid<=0 (flush).
  - Overrides fire, stall, halt_req and HALT, and forces state=RUN.
- halt_req in RUN with no redirect: state<=HALT; no fire that cycle.
  - A pending output packet stays valid until accepted.
- HALT exits only via redirect.
- ADEF (pc[1:0]!=0) on fire:
  - Packet is emitted with out_adef=1, out_mask one-hot at slot, out_taken=0.
  - pc is not advanced; state<=HALT until a redirect.
- Stall (out_valid && !out_ready): all out_* hold, pc holds, and fetch_pc is stable for BTB re-lookup.
- FETCH_W=1: mask is always 1 bit; pred_slot is ignored (taken implies slot 0).

Test Plan:
1. FETCH_W=2, reset then out_ready=1 -> packets at 0x1c000000, 0x1c000008, 0x1c000010, each mask=2'b11, out_next_pc = pc+8.
2. redir_valid[1] target 0x1c000104 -> following packet out_pc=0x1c000104, mask=2'b10, next=0x1c000108; the next packet is aligned 0x1c000108, mask=2'b11.
3. redir_valid=4'b0110 with targets 0x100 (src1) and 0x200 (src2) -> src1 wins, next packet out_pc=0x100.
4. fetch_pc=0x1c000020, pred_taken=1, pred_slot=0, pred_pc=0x1c000400 -> mask=2'b01, out_taken=1, next packet 0x1c000400.
5. out_ready=0 for 5 cycles then redirect -> outputs hold during the stall, then out_valid drops the cycle after the redirect; no duplicate or lost packets.
6. halt_req -> halted=1, no packets; redirect to 0x1c000102 -> ADEF packet mask=2'b01, halted=1 again; PC_RESET=0xFFFFFFF8 reset -> first next_pc=0x00000000.
